stage_latch_q: RTL
==================

Name: stage_latch_q

Overview:
- Parametrised pipeline-stage latch for the 5-stage core. Sits between producer stage STAGE and consumer stage STAGE+1; the IF/ID boundary is the first user.
- Carries the existing stall-vector / flush / bubble semantics.
- Adds a valid bit, generic PC/payload widths, and a DEPTH-entry skid queue. The queue absorbs producer results that arrive while the consumer is stalled, e.g. an instruction-memory return landing during a load-use stall.

Parameters:
- PC_W, 32, width of the PC field
- DATA_W, 32, width of the payload field (instruction word at IF/ID)
- DEPTH, 2, skid queue entries; power of two, at least 2
- STALL_W, 6, width of the global stall vector
- STAGE, 1, index of the producer stage in the stall vector; consumer index is STAGE+1, so STAGE+1 < STALL_W

Ports:
- clk  in  1  clock; all state on the rising edge
- rst  in  1  reset, asynchronous, active-low
- stall  in  STALL_W  global stall vector; 1 = stop
- flush  in  1  pipeline flush, synchronous
- in_valid  in  1  producer result is valid this cycle
- in_pc  in  PC_W  producer PC
- in_data  in  DATA_W  producer payload
- in_ready  out  1  queue can accept a push; combinational = (count < DEPTH)
- out_valid  out  1  registered; consumer-side entry is real (0 = bubble)
- out_pc  out  PC_W  registered
- out_data  out  DATA_W  registered
- count  out  $clog2(DEPTH+1)  current queue occupancy
- overflow  out  1  sticky error flag

Behaviour:
- Definitions:
  - dn = stall[STAGE+1]; up = stall[STAGE].
  - qe = (count == 0).
  - acc = in_valid & in_ready & ~flush.
- Reset (rst = 0, asynchronous, any time, including mid-stall):
  - out_valid, out_pc, out_data, count, overflow and the queue pointers all go to 0.
  - Queue contents are don't-care.
- Output register update, evaluated per rising edge, first match wins:
  1. flush = 1: output becomes a bubble (valid 0, pc 0, data 0). Queue is emptied (count 0, pointers 0). The input is dropped even if in_valid is 1.
  2. dn = 1: output holds. Input is pushed if acc.
  3. dn = 0 and ~qe: the queue head is popped into the output with valid 1. Input is pushed at the tail if acc.
     - Simultaneous pop and push leaves count unchanged.
     - When count = DEPTH, in_ready is 0, so no push happens that cycle.
  4. dn = 0, qe and acc: bypass. Input loads directly into the output with valid 1, and the queue is untouched. Latency is 1 cycle from in_valid to out_valid.
  5. Otherwise: output becomes a bubble (valid 0, pc 0, data 0).
- The up=1 / dn=0 case:
  - Queued entries still drain; this is the generalisation of the previous bubble-only rule.
  - If the queue is empty and there is no input, the output is a bubble.
- Ordering: strict FIFO. Bypass only occurs with an empty queue, so program order is always preserved.
- Queue internals:
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits, wrapping naturally at DEPTH.
  - count is tracked separately. Full is count == DEPTH; empty is count == 0.
- overflow:
  - Set on any edge where in_valid = 1, in_ready = 0 and flush = 0.
  - Stays set until reset.
  - The offending input is discarded; the queue and output are not corrupted.
- flush together with dn = 1: flush wins, and the output bubbles despite the stall.
- No combinational path from in_* to out_*. The only combinational output is in_ready, which depends on count only.

Decomposition:
- Shared package / defines:
  - active-low reset level
  - Stop/NoStop encodings
  - ZeroWord
  - stall-vector stage indices (PC=0, IF=1, ID=2, EX=3, MEM=4, WB=5)
  - default PC_W / DATA_W
- One sub-module, stage_skid_fifo:
  - parameters WIDTH = PC_W + DATA_W and DEPTH
  - push/pop/clear ports, head data, count
  - no bypass logic inside it; bypass belongs to stage_latch_q
- Top level contains the output register and the priority logic only.

Test Plan:
- Reset then free run: dn = 0, in_valid = 1 with pc 0x100, 0x104, 0x108 on successive cycles -> out_pc follows 1 cycle later, out_valid = 1, count stays 0.
- Stall absorb: hold dn = 1 for 3 cycles while pushing 0x200 and 0x204 (DEPTH = 2) -> output holds its prior value, count = 2, in_ready = 0. Then release dn -> outputs 0x200, then 0x204, count returns to 0, overflow = 0.
- Overflow: keep dn = 1, queue full, in_valid = 1 with pc 0x300 -> overflow = 1 and stays set. After release, only the two earlier entries emerge and 0x300 never appears.
- Flush priority: queue holds 2 entries, dn = 1, then flush = 1 with in_valid = 1 -> next cycle out_valid = 0, pc = 0, data = 0, count = 0. The flushed entries and the input are never emitted.
- Bubble and drain: up = 1, dn = 0, queue holds 1 entry -> entry emitted. Next cycle with in_valid = 0 -> bubble (out_valid = 0, out_pc = 0).
- Async reset mid-stall: with count = 2, assert rst low between clock edges -> all outputs and count go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stage_latch_q_pkg.sv
// Shared encodings for the pipeline-stage latch: reset level, stall polarity,
// stall-vector stage indices and the per-edge action selected by the latch.
package stage_latch_q_pkg;

  localparam logic RST_ACTIVE = 1'b0;
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;

  localparam int PC_W_DEF   = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum int unsigned {
    STG_PC  = 0,
    STG_IF  = 1,
    STG_ID  = 2,
    STG_EX  = 3,
    STG_MEM = 4,
    STG_WB  = 5
  } stall_idx_e;

  // Ordered by priority: the first applicable action wins on each edge.
  typedef enum logic [2:0] {
    ACT_FLUSH,
    ACT_HOLD,
    ACT_POP,
    ACT_BYPASS,
    ACT_BUBBLE
  } latch_act_e;

endpackage

// File: rtl/stage_latch_q_if.sv
// Producer/consumer bundle for one pipeline-stage boundary. The master side
// drives stall/flush and the producer result; the slave side is the latch.
interface stage_latch_q_if #(
  parameter int PC_W    = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 2,
  parameter int STALL_W = 6
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               in_valid;
  logic [PC_W-1:0]    in_pc;
  logic [DATA_W-1:0]  in_data;
  logic               in_ready;
  logic               out_valid;
  logic [PC_W-1:0]    out_pc;
  logic [DATA_W-1:0]  out_data;
  logic [CNT_W-1:0]   count;
  logic               overflow;

  modport master (
    output stall, flush, in_valid, in_pc, in_data,
    input  in_ready, out_valid, out_pc, out_data, count, overflow
  );

  modport slave (
    input  stall, flush, in_valid, in_pc, in_data,
    output in_ready, out_valid, out_pc, out_data, count, overflow
  );

endinterface

// File: rtl/stage_latch_q_skid_fifo.sv
// Circular skid queue used by stage_latch_q to hold producer results while the
// consumer stalls. Push on full and pop on empty are ignored.
module stage_skid_fifo
  import stage_latch_q_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = i_push & ~w_full & ~i_clear;
  assign w_do_pop  = i_pop & ~w_empty & ~i_clear;

  // NOTE: non-blocking assignments for all state so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by r_count, so stale
  // entries are never observed and the array maps onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/stage_latch_q.sv
// Pipeline-stage latch between stage STAGE and STAGE+1: registered output with
// flush/hold/bubble priority, a one-cycle bypass and a skid queue for stalls.
module stage_latch_q
  import stage_latch_q_pkg::*;
#(
  parameter  int PC_W    = PC_W_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int DEPTH   = 2,
  parameter  int STALL_W = 6,
  parameter  int STAGE   = STG_IF,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int ENT_W   = PC_W + DATA_W
) (
  input  logic           clk,
  input  logic           rst,
  stage_latch_q_if.slave bus
);

  logic             w_dn;
  logic             w_qe;
  logic             w_ready;
  logic             w_acc;
  logic             w_push;
  logic             w_pop;
  latch_act_e       w_act;
  logic [ENT_W-1:0] w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_unused_stall;

  logic              r_out_valid;
  logic [PC_W-1:0]   r_out_pc;
  logic [DATA_W-1:0] r_out_data;
  logic              r_overflow;

  assign w_dn    = (bus.stall[STAGE+1] == STOP);
  assign w_qe    = (w_count == '0);
  assign w_ready = (w_count < CNT_W'(DEPTH));
  assign w_acc   = bus.in_valid & w_ready & ~bus.flush;

  // Only the consumer's stall bit affects behaviour; the rest of the vector,
  // including the producer's own bit, is deliberately ignored.
  assign w_unused_stall = ^bus.stall;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_act = ACT_BUBBLE;
    if (bus.flush)  w_act = ACT_FLUSH;
    else if (w_dn)  w_act = ACT_HOLD;
    else if (!w_qe) w_act = ACT_POP;
    else if (w_acc) w_act = ACT_BYPASS;
  end

  assign w_push = w_acc & ((w_act == ACT_HOLD) | (w_act == ACT_POP));
  assign w_pop  = (w_act == ACT_POP);

  stage_skid_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_clear (bus.flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({bus.in_pc, bus.in_data}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_data  <= '0;
    end else begin
      unique case (w_act)
        ACT_HOLD: begin
          r_out_valid <= r_out_valid;
          r_out_pc    <= r_out_pc;
          r_out_data  <= r_out_data;
        end
        ACT_POP: begin
          r_out_valid <= 1'b1;
          r_out_pc    <= w_head[ENT_W-1:DATA_W];
          r_out_data  <= w_head[DATA_W-1:0];
        end
        ACT_BYPASS: begin
          r_out_valid <= 1'b1;
          r_out_pc    <= bus.in_pc;
          r_out_data  <= bus.in_data;
        end
        default: begin
          r_out_valid <= 1'b0;
          r_out_pc    <= PC_W'(ZERO_WORD);
          r_out_data  <= DATA_W'(ZERO_WORD);
        end
      endcase
    end
  end

  // Sticky: a valid result offered while the queue is full is lost for good.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      r_overflow <= 1'b0;
    end else if (bus.in_valid & ~w_ready & ~bus.flush) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_pc    = r_out_pc;
  assign bus.out_data  = r_out_data;
  assign bus.count     = w_count;
  assign bus.overflow  = r_overflow;

endmodule
